// File: rtl/jk_pkg.sv
// Shared constants for the JK up/down counter.
// JK command encodings and the default counter width.
package jk_pkg;

  typedef logic [1:0] jk_cmd_t;

  localparam jk_cmd_t JK_HOLD = 2'b00;
  localparam jk_cmd_t JK_CLR  = 2'b01;
  localparam jk_cmd_t JK_SET  = 2'b10;
  localparam jk_cmd_t JK_TOG  = 2'b11;

  localparam int JK_CNT_W = 4;

  function automatic jk_cmd_t jk_pack(
    input logic j,
    input logic k
  );
    return {j, k};
  endfunction

endpackage

// File: rtl/jk_stage.sv
// One JK flip-flop stage with asynchronous active-low clear.
// Outputs the stored bit and its complement.
module jk_stage
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case (jk_pack(j, k))
      JK_HOLD: q_d = q_q;
      JK_CLR:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TOG:  q_d = ~q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Synchronous up/down counter built from JK stages with parallel load.
// Define JK_CNT_SAT_EN to saturate at the ends instead of wrapping.
module jk_updown_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = JK_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] qb_w;
  logic             at_end;
  logic             hold_all;

  // Ripple toggle chain: a bit flips when all lower bits sit at the carry/borrow value.
  always_comb begin
    t    = '0;
    t[0] = en;
    for (int i = 1; i < WIDTH; i++) begin
      t[i] = t[i-1] & (up ? q_w[i-1] : ~q_w[i-1]);
    end
  end

  assign at_end = up ? (&q_w) : ~(|q_w);
  assign tc     = en & at_end;

`ifdef JK_CNT_SAT_EN
  assign hold_all = tc & ~load;
`else
  assign hold_all = 1'b0;
`endif

  always_comb begin
    j = '0;
    k = '0;
    unique case (1'b1)
      load: begin
        j = din;
        k = ~din;
      end
      hold_all: begin
        j = '0;
        k = '0;
      end
      default: begin
        j = t;
        k = t;
      end
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_stage
    jk_stage u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j[g]),
      .k     (k[g]),
      .q     (q_w[g]),
      .qb    (qb_w[g])
    );
  end

  assign q  = q_w;
  assign qb = qb_w;

endmodule

// File: doc/jk_updown_counter.md
JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  count enable; when high, the counter advances one step per rising edge.
REQ-005 up  input  1  direction select; 1 = increment, 0 = decrement.
REQ-006 load  input  1  synchronous parallel load of din.
REQ-007 din  input  WIDTH  parallel load value.
REQ-008 q  output  WIDTH  counter state, taken directly from the flip-flop stage outputs.
REQ-009 qb  output  WIDTH  bitwise complement of q, taken from the stage complement outputs.
REQ-010 tc  output  1  terminal count: high when en=1 and q is at the end of the count in the current direction.

Function
REQ-011 Each bit of the counter SHALL be one JK stage using standard JK semantics: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-012 Toggle chain SHALL be as follows:
- t[0] = en.
- When up=1: t[i] = t[i-1] & q[i-1].
- When up=0: t[i] = t[i-1] & ~q[i-1].
- Stage i receives j = k = t[i].
REQ-013 When load=1, stage i SHALL receive j = din[i] and k = ~din[i], so that q = din after the next rising edge.
REQ-014 load SHALL take priority over en; up is ignored while load=1.
REQ-015 Latency SHALL be one clock: q reflects a load or count step after the first rising edge at which the command was sampled.
REQ-016 With en=0 and load=0, all stages SHALL receive JK = 00 and q SHALL hold.
REQ-017 tc SHALL be combinational:
- tc = en & up & (q == all ones), or
- tc = en & ~up & (q == 0).
REQ-018 Wrap-around (default build) SHALL apply at the ends of the range:
- Incrementing from all ones gives 0.
- Decrementing from 0 gives all ones.
REQ-019 When up changes between edges, the next step SHALL use the new direction; no idle cycle is inserted.
REQ-020 qb SHALL equal ~q at all times outside reset transitions.

Reset
REQ-021 On rst_n low, the following SHALL happen immediately, independent of clk:
- q SHALL be 0.
- qb SHALL be all ones.
- tc SHALL follow REQ-017 from q = 0.
REQ-022 Reset SHALL override load and en, including reset asserted in the middle of a count sequence.
REQ-023 The first rising edge after rst_n deasserts SHALL act on the inputs sampled at that edge.

Configuration
REQ-024 Macro JK_CNT_SAT_EN SHALL select saturating behaviour:
- Defined: when tc=1 and load=0, all stages SHALL receive JK = 00 and q SHALL hold at the end value (all ones going up, 0 going down).
- Not defined: the counter wraps per REQ-018.

Structure
REQ-025 Shared package jk_pkg SHALL hold:
- JK command constants: JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TOG=2'b11.
- Default width constant JK_CNT_W=4.
REQ-026 Sub-module jk_stage SHALL implement one JK flip-flop:
- Ports: clk, rst_n, j, k, q, qb.
- Asynchronous active-low clear.
- Instantiated WIDTH times by a generate loop.
REQ-027 Command steering SHALL be plain combinational logic in the top level:
- Load, enable and direction select the j/k value of each stage.
- Under JK_CNT_SAT_EN, saturation forces all stages to hold.

Verification
REQ-028 Reset: drive rst_n=0 mid-cycle with en=1 -> q=0000 and qb=1111 immediately; after release, q=0001 one edge later (up=1).
REQ-029 Count up: en=1, up=1 for 17 edges from reset -> q steps 1,2,...,15,0,1; tc=1 only while q=1111.
REQ-030 Count down plus load: load=1 with din=0101, then load=0, en=1, up=0 -> q=0101, 0100, 0011.
REQ-031 Priority: load=1, en=1, up=1, din=1010 on the same edge -> q=1010, not incremented.
REQ-032 Saturation: build with JK_CNT_SAT_EN, load 1110, count up for 3 edges -> q=1111, 1111, 1111 with tc held at 1; without the macro -> q=1111, 0000, 0001.
REQ-033 Hold: en=0, load=0 for 5 edges at q=0110 -> q stays 0110, tc=0, qb=1001.
